word_byte_serializer: RTL and testbench



---
 rtl/word_byte_serializer_if.sv | 28 ++
 rtl/word_byte_serializer.sv | 123 ++++++++++++
 tb/tb_word_byte_serializer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_byte_serializer_if.sv
// rtl/word_byte_serializer_if.sv - word-in / byte-out handshake bundle for word_byte_serializer
interface word_byte_serializer_if #(
  parameter int BYTE_W  = 8,
  parameter int N_BYTES = 4,
  parameter int ADDR_W  = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [BYTE_W*N_BYTES-1:0]   in_data;
  logic [ADDR_W-1:0]           in_addr;
  logic                        out_valid;
  logic                        out_ready;
  logic [BYTE_W-1:0]           out_byte;
  logic [ADDR_W-1:0]           out_addr;
  logic                        out_parity;
  logic                        out_last;
  logic                        busy;

  modport master (
    output in_valid, in_data, in_addr, out_ready,
    input  in_ready, out_valid, out_byte, out_addr, out_parity, out_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_addr, out_ready,
    output in_ready, out_valid, out_byte, out_addr, out_parity, out_last, busy
  );
endinterface

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - serializes held words into addressed, parity-tagged byte beats
// Single-word buffer; the next word is accepted on the last beat's transfer so streams run without bubbles.
module word_byte_serializer #(
  parameter int BYTE_W    = 8,
  parameter int N_BYTES   = 4,
  parameter int ADDR_W    = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  word_byte_serializer_if.slave bus
);

  localparam int WORD_W = BYTE_W * N_BYTES;
  localparam int IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                out_valid_q, out_valid_d;
  logic [BYTE_W-1:0]   out_byte_q, out_byte_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_parity_q, out_parity_d;
  logic                out_last_q, out_last_d;

  logic                beat_fire;
  logic                accept;
  logic [WORD_W-1:0]   src_word;
  logic [ADDR_W-1:0]   src_base;
  logic [IDX_W-1:0]    src_idx;
  logic [IDX_W-1:0]    src_sel;
  logic [BYTE_W-1:0]   src_byte;

  assign beat_fire    = out_valid_q & bus.out_ready;
  assign bus.in_ready = (state_q == IDLE) | (beat_fire & out_last_q);
  assign accept       = bus.in_valid & bus.in_ready;

  // The beat presented next comes either from a freshly accepted word or the following index of the held one.
  always_comb begin
    if (accept) begin
      src_word = bus.in_data;
      src_base = bus.in_addr;
      src_idx  = '0;
    end else begin
      src_word = word_q;
      src_base = base_q;
      src_idx  = idx_q + IDX_W'(1);
    end
    src_sel  = MSB_FIRST ? (LAST_IDX - src_idx) : src_idx;
    src_byte = src_word[BYTE_W*int'(src_sel) +: BYTE_W];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    word_d       = word_q;
    base_d       = base_q;
    out_valid_d  = out_valid_q;
    out_byte_d   = out_byte_q;
    out_addr_d   = out_addr_q;
    out_parity_d = out_parity_q;
    out_last_d   = out_last_q;

    if (accept || (beat_fire && !out_last_q)) begin
      state_d      = SEND;
      idx_d        = src_idx;
      word_d       = src_word;
      base_d       = src_base;
      out_valid_d  = 1'b1;
      out_byte_d   = src_byte;
      out_addr_d   = src_base + ADDR_W'(src_sel);
      out_parity_d = ^src_byte;
      out_last_d   = (src_idx == LAST_IDX);
    end else if (beat_fire) begin
      state_d      = IDLE;
      idx_d        = '0;
      out_valid_d  = 1'b0;
      out_byte_d   = '0;
      out_addr_d   = '0;
      out_parity_d = 1'b0;
      out_last_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      base_q       <= '0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= '0;
      out_addr_q   <= '0;
      out_parity_q <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      base_q       <= base_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      out_addr_q   <= out_addr_d;
      out_parity_q <= out_parity_d;
      out_last_q   <= out_last_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_byte   = out_byte_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_parity = out_parity_q;
  assign bus.out_last   = out_last_q;
  assign bus.busy       = (state_q == SEND);

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb/tb_word_byte_serializer.sv - self-checking bench for word_byte_serializer (LSB-first and MSB-first instances)
module tb_word_byte_serializer;
  localparam int BYTE_W  = 8;
  localparam int N_BYTES = 4;
  localparam int ADDR_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [7:0]  b;
    logic [31:0] a;
    logic        p;
    logic        l;
    int          c;
  } beat_t;

  beat_t obs0[$], exp0[$], obs1[$], exp1[$];
  int    acc0[$], acc1[$];

  word_byte_serializer_if #(.BYTE_W(BYTE_W), .N_BYTES(N_BYTES), .ADDR_W(ADDR_W)) if0 ();
  word_byte_serializer_if #(.BYTE_W(BYTE_W), .N_BYTES(N_BYTES), .ADDR_W(ADDR_W)) if1 ();

  word_byte_serializer #(.BYTE_W(BYTE_W), .N_BYTES(N_BYTES), .ADDR_W(ADDR_W), .MSB_FIRST(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  word_byte_serializer #(.BYTE_W(BYTE_W), .N_BYTES(N_BYTES), .ADDR_W(ADDR_W), .MSB_FIRST(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: a word expands into N_BYTES beats, byte j = (word >> 8j) & FF at base + j.
  function automatic beat_t model_beat(bit msb, logic [31:0] word, logic [31:0] base, int k);
    beat_t t;
    int j;
    j   = msb ? (N_BYTES - 1 - k) : k;
    t.b = 8'((word >> (8 * j)) & 32'hFF);
    t.a = base + 32'(j);
    t.p = (($countones(t.b) % 2) == 1);
    t.l = (k == N_BYTES - 1);
    t.c = 0;
    return t;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.out_valid && if0.out_ready)
        obs0.push_back('{if0.out_byte, if0.out_addr, if0.out_parity, if0.out_last, cyc});
      if (if1.out_valid && if1.out_ready)
        obs1.push_back('{if1.out_byte, if1.out_addr, if1.out_parity, if1.out_last, cyc});
      if (if0.in_valid && if0.in_ready) begin
        acc0.push_back(cyc);
        for (int k = 0; k < N_BYTES; k++) exp0.push_back(model_beat(1'b0, if0.in_data, if0.in_addr, k));
      end
      if (if1.in_valid && if1.in_ready) begin
        acc1.push_back(cyc);
        for (int k = 0; k < N_BYTES; k++) exp1.push_back(model_beat(1'b1, if1.in_data, if1.in_addr, k));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    obs0.delete(); exp0.delete(); acc0.delete();
    obs1.delete(); exp1.delete(); acc1.delete();
  endtask

  task automatic offer0(input logic [31:0] d, input logic [31:0] a, output bit ok);
    ok = 1'b0;
    if0.in_valid = 1'b1;
    if0.in_data  = d;
    if0.in_addr  = a;
    for (int n = 0; n < 50 && !ok; n++) begin
      #1;
      ok = if0.in_ready;
      tick();
    end
    if0.in_valid = 1'b0;
  endtask

  task automatic offer1(input logic [31:0] d, input logic [31:0] a, output bit ok);
    ok = 1'b0;
    if1.in_valid = 1'b1;
    if1.in_data  = d;
    if1.in_addr  = a;
    for (int n = 0; n < 50 && !ok; n++) begin
      #1;
      ok = if1.in_ready;
      tick();
    end
    if1.in_valid = 1'b0;
  endtask

  task automatic wait_beats0(input int n);
    for (int i = 0; i < 300 && obs0.size() < n; i++) tick();
  endtask

  task automatic wait_beats1(input int n);
    for (int i = 0; i < 300 && obs1.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({if0.out_valid, if0.busy, if0.out_parity, if0.out_last, if0.out_byte, if0.out_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outs0 got=%b/%b/%h/%h exp=0", if0.out_valid, if0.busy, if0.out_byte, if0.out_addr);
    end
    checks++;
    if ({if1.out_valid, if1.busy, if1.out_parity, if1.out_last, if1.out_byte, if1.out_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outs1 got=%b/%b/%h/%h exp=0", if1.out_valid, if1.busy, if1.out_byte, if1.out_addr);
    end
    checks++;
    if ({if0.in_ready, if1.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_in_ready got=%b%b exp=11", if0.in_ready, if1.in_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] eb [4];
    logic       ep [4];
    eb = '{8'hFE, 8'hCA, 8'hCE, 8'hFA};
    ep = '{1'b1, 1'b0, 1'b1, 1'b0};
    clear_all();
    offer0(32'hFACE_CAFE, 32'h100, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL single_accept got=%b exp=1", ok); end
    wait_beats0(4);
    checks++;
    if ({if0.out_valid, if0.busy} !== 2'b00) begin
      errors++; $display("FAIL single_idle_after got=%b%b exp=00", if0.out_valid, if0.busy);
    end
    checks++;
    if (obs0.size() != 4 || acc0.size() != 1) begin
      errors++; $display("FAIL single_count got=%0d exp=4", obs0.size());
    end
    for (int i = 0; i < obs0.size() && i < 4 && acc0.size() > 0; i++) begin
      checks++;
      if ({obs0[i].b, obs0[i].a, obs0[i].p, obs0[i].l} !== {eb[i], 32'h100 + 32'(i), ep[i], i == 3}) begin
        errors++;
        $display("FAIL single_beat%0d got=%h@%h p%b l%b exp=%h@%h p%b", i, obs0[i].b, obs0[i].a, obs0[i].p, obs0[i].l,
                 eb[i], 32'h100 + 32'(i), ep[i]);
      end
      checks++;
      if (obs0[i].c != acc0[0] + 1 + i) begin
        errors++; $display("FAIL single_timing%0d got=%0d exp=%0d", i, obs0[i].c, acc0[0] + 1 + i);
      end
    end
  endtask

  task automatic test_msb_first();
    bit ok;
    logic [7:0] eb [4];
    logic       ep [4];
    eb = '{8'hFA, 8'hCE, 8'hCA, 8'hFE};
    ep = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_all();
    offer1(32'hFACE_CAFE, 32'h100, ok);
    wait_beats1(4);
    checks++;
    if (obs1.size() != 4 || ok !== 1'b1) begin
      errors++; $display("FAIL msb_count got=%0d exp=4", obs1.size());
    end
    for (int i = 0; i < obs1.size() && i < 4; i++) begin
      checks++;
      if ({obs1[i].b, obs1[i].a, obs1[i].p, obs1[i].l} !== {eb[i], 32'h103 - 32'(i), ep[i], i == 3}) begin
        errors++;
        $display("FAIL msb_beat%0d got=%h@%h p%b l%b exp=%h@%h p%b", i, obs1[i].b, obs1[i].a, obs1[i].p, obs1[i].l,
                 eb[i], 32'h103 - 32'(i), ep[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, acc, last_at_ready;
    int waits;
    logic [7:0] eb [8];
    eb = '{8'hFE, 8'hCA, 8'hCE, 8'hFA, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_all();
    acc = 1'b0; waits = 0; last_at_ready = 1'b0;
    offer0(32'hFACE_CAFE, 32'h0, ok);
    if0.in_valid = 1'b1;
    if0.in_data  = 32'h1234_5678;
    if0.in_addr  = 32'h4;
    for (int n = 0; n < 20 && !acc; n++) begin
      #1;
      if (if0.in_ready) begin
        acc = 1'b1;
        last_at_ready = if0.out_valid & if0.out_last & if0.out_ready;
      end else begin
        waits++;
      end
      tick();
    end
    if0.in_valid = 1'b0;
    checks++;
    if (!acc || !last_at_ready || waits != 3) begin
      errors++; $display("FAIL b2b_in_ready got=acc%b last%b waits%0d exp=acc1 last1 waits3", acc, last_at_ready, waits);
    end
    wait_beats0(8);
    checks++;
    if (obs0.size() != 8 || exp0.size() != 8) begin
      errors++; $display("FAIL b2b_count got=%0d exp=8", obs0.size());
    end
    for (int i = 0; i < obs0.size() && i < 8 && i < exp0.size(); i++) begin
      checks++;
      if ({obs0[i].b, obs0[i].a, obs0[i].l} !== {eb[i], 32'(i), i == 3 || i == 7} ||
          {obs0[i].b, obs0[i].a, obs0[i].p, obs0[i].l} !== {exp0[i].b, exp0[i].a, exp0[i].p, exp0[i].l} ||
          obs0[i].c != obs0[0].c + i) begin
        errors++;
        $display("FAIL b2b_beat%0d got=%h@%h l%b cyc%0d exp=%h@%h cyc%0d", i, obs0[i].b, obs0[i].a, obs0[i].l,
                 obs0[i].c, eb[i], 32'(i), obs0[0].c + i);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] eb [4];
    eb = '{8'hFE, 8'hCA, 8'hCE, 8'hFA};
    clear_all();
    offer0(32'hFACE_CAFE, 32'h100, ok);
    tick();
    if0.out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if0.in_data = $urandom;
      if0.in_addr = $urandom;
      #1;
      checks++;
      if ({if0.out_valid, if0.out_byte, if0.out_addr, if0.out_parity, if0.out_last} !== {1'b1, 8'hCA, 32'h101, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall%0d got=v%b %h@%h p%b l%b exp=v1 ca@00000101 p0 l0", s, if0.out_valid, if0.out_byte,
                 if0.out_addr, if0.out_parity, if0.out_last);
      end
      tick();
    end
    if0.out_ready = 1'b1;
    wait_beats0(4);
    checks++;
    if (obs0.size() != 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", obs0.size()); end
    for (int i = 0; i < obs0.size() && i < 4 && i < exp0.size(); i++) begin
      checks++;
      if (obs0[i].b !== eb[i] || obs0[i].a !== exp0[i].a || obs0[i].p !== exp0[i].p) begin
        errors++; $display("FAIL stall_beat%0d got=%h@%h exp=%h@%h", i, obs0[i].b, obs0[i].a, eb[i], exp0[i].a);
      end
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    logic [31:0] ea [4];
    logic [7:0]  eb [4];
    logic        ep [4];
    ea = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    eb = '{8'h01, 8'h00, 8'h00, 8'h00};
    ep = '{1'b1, 1'b0, 1'b0, 1'b0};
    clear_all();
    offer0(32'h0000_0001, 32'hFFFF_FFFE, ok);
    wait_beats0(4);
    checks++;
    if (obs0.size() != 4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", obs0.size()); end
    for (int i = 0; i < obs0.size() && i < 4; i++) begin
      checks++;
      if ({obs0[i].b, obs0[i].a, obs0[i].p} !== {eb[i], ea[i], ep[i]}) begin
        errors++;
        $display("FAIL wrap_beat%0d got=%h@%h p%b exp=%h@%h p%b", i, obs0[i].b, obs0[i].a, obs0[i].p, eb[i], ea[i], ep[i]);
      end
    end
  endtask

  task automatic test_random();
    int remaining, target;
    bit prev_stall, acc;
    logic [7:0]  pb;
    logic [31:0] pa;
    logic        pp, pl, pv;
    remaining = 24;
    target = 4 * remaining;
    prev_stall = 1'b0;
    pb = '0; pa = '0; pp = 1'b0; pl = 1'b0; pv = 1'b0;
    clear_all();
    for (int n = 0; n < 3000 && (remaining > 0 || obs0.size() < target); n++) begin
      if0.out_ready = ($urandom_range(0, 3) != 0);
      if (!if0.in_valid && remaining > 0 && $urandom_range(0, 1) == 1) begin
        if0.in_valid = 1'b1;
        if0.in_data  = $urandom;
        if0.in_addr  = $urandom;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if ({if0.out_valid, if0.out_byte, if0.out_addr, if0.out_parity, if0.out_last} !== {pv, pb, pa, pp, pl}) begin
          errors++;
          $display("FAIL rand_stall_hold got=%h@%h exp=%h@%h", if0.out_byte, if0.out_addr, pb, pa);
        end
      end
      prev_stall = if0.out_valid && !if0.out_ready;
      {pv, pb, pa, pp, pl} = {if0.out_valid, if0.out_byte, if0.out_addr, if0.out_parity, if0.out_last};
      acc = if0.in_valid && if0.in_ready;
      tick();
      if (acc) begin
        if0.in_valid = 1'b0;
        remaining--;
      end
    end
    if0.out_ready = 1'b1;
    checks++;
    if (obs0.size() != target || exp0.size() != target) begin
      errors++; $display("FAIL rand_count got=%0d/%0d exp=%0d", obs0.size(), exp0.size(), target);
    end
    for (int i = 0; i < obs0.size() && i < exp0.size(); i++) begin
      checks++;
      if ({obs0[i].b, obs0[i].a, obs0[i].p, obs0[i].l} !== {exp0[i].b, exp0[i].a, exp0[i].p, exp0[i].l}) begin
        errors++;
        $display("FAIL rand_beat%0d got=%h@%h p%b l%b exp=%h@%h p%b l%b", i, obs0[i].b, obs0[i].a, obs0[i].p,
                 obs0[i].l, exp0[i].b, exp0[i].a, exp0[i].p, exp0[i].l);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    bit ok;
    clear_all();
    offer0(32'hFACE_CAFE, 32'h100, ok);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if0.out_valid, if0.busy, if0.out_parity, if0.out_last, if0.out_byte, if0.out_addr} !== '0) begin
      errors++;
      $display("FAIL midreset_outs got=%b/%b/%h/%h exp=0", if0.out_valid, if0.busy, if0.out_byte, if0.out_addr);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b exp=1", if0.in_ready); end
    repeat (6) tick();
    checks++;
    if (obs0.size() != 2 || if0.out_valid !== 1'b0 || if0.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_stale got=%0d beats v%b exp=2 beats v0", obs0.size(), if0.out_valid);
    end
    checks++;
    if (obs0.size() < 2 || obs0[0].b !== 8'hFE || obs0[1].b !== 8'hCA) begin
      errors++; $display("FAIL midreset_pre_beats got=%0d beats exp=FE,CA", obs0.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_addr = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_addr = '0; if1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    test_reset();
    tick();
    test_single();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_addr_wrap();
    test_random();
    tick();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
